// File: rtl/axi_handshake_checker.sv
// VALID/READY protocol checker for one AXI address channel and its data channel.
// Flags payload-hold and valid-drop violations, plus optional burst LAST/ordering checks.
module axi_handshake_checker #(
    parameter int ADDR_PL_WIDTH  = 64,
    parameter int DATA_PL_WIDTH  = 64,
    parameter int LEN_FIFO_DEPTH = 8,
    parameter int BURST_CHECK    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             addr_valid,
    input  logic                             addr_ready,
    input  logic [ADDR_PL_WIDTH-1:0]         addr_payload,
    input  logic [7:0]                       addr_len,
    input  logic                             data_valid,
    input  logic                             data_ready,
    input  logic [DATA_PL_WIDTH-1:0]         data_payload,
    input  logic                             data_last,
    output logic                             err_valid,
    output logic [2:0]                       err_code,
    output logic [6:0]                       err_mask,
    output logic [15:0]                      err_count,
    output logic [$clog2(LEN_FIFO_DEPTH):0]  outstanding
);
    localparam int              PTR_W    = $clog2(LEN_FIFO_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LEN_FIFO_DEPTH);
    localparam bit              BURST_EN = (BURST_CHECK != 0);

    logic                     prev_addr_valid, prev_addr_ready;
    logic                     prev_data_valid, prev_data_ready, prev_data_last;
    logic [ADDR_PL_WIDTH-1:0] prev_addr_payload;
    logic [7:0]               prev_addr_len;
    logic [DATA_PL_WIDTH-1:0] prev_data_payload;

    logic [7:0]       len_mem [LEN_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       beat_cnt;

    logic       addr_hs, data_hs, fifo_empty, fifo_full;
    logic       bypass, have_head, expected_last, push, pop;
    logic [7:0] head_len;
    logic [6:0] err_vec, err_pend;
    logic [2:0] pend_code;

    always_comb begin
        addr_hs       = addr_valid & addr_ready;
        data_hs       = data_valid & data_ready;
        fifo_empty    = (count == '0);
        fifo_full     = (count == FULL_CNT);
        // An empty queue can still serve a beat if its address arrives in the same cycle.
        bypass        = fifo_empty & addr_hs & data_hs;
        head_len      = bypass ? addr_len : len_mem[rd_ptr];
        have_head     = ~fifo_empty | bypass;
        expected_last = (beat_cnt == head_len);
        pop           = BURST_EN & data_hs & have_head & (data_last | expected_last);
        push          = BURST_EN & addr_hs & (~fifo_full | pop);

        err_vec = '0;
        if (prev_addr_valid && !prev_addr_ready) begin
            err_vec[0] = (addr_payload !== prev_addr_payload) || (addr_len !== prev_addr_len);
            err_vec[1] = ~addr_valid;
        end
        if (prev_data_valid && !prev_data_ready) begin
            err_vec[2] = (data_payload !== prev_data_payload) || (data_last !== prev_data_last);
            err_vec[3] = ~data_valid;
        end
        if (BURST_EN) begin
            err_vec[4] = data_hs & have_head & (data_last != expected_last);
            err_vec[5] = addr_hs & fifo_full & ~pop;
            err_vec[6] = data_hs & ~have_head;
        end
    end

    always_comb begin
        pend_code = '0;
        for (int i = 6; i >= 0; i--) begin
            if (err_pend[i]) pend_code = 3'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) len_mem[wr_ptr] <= addr_len;
    end

    always_ff @(posedge clk) begin
        prev_addr_payload <= addr_payload;
        prev_addr_len     <= addr_len;
        prev_data_payload <= data_payload;
        prev_data_last    <= data_last;
        if (rst) begin
            prev_addr_valid <= 1'b0;
            prev_addr_ready <= 1'b0;
            prev_data_valid <= 1'b0;
            prev_data_ready <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            beat_cnt        <= '0;
            err_pend        <= '0;
            err_valid       <= 1'b0;
            err_code        <= '0;
            err_mask        <= '0;
            err_count       <= '0;
        end else begin
            prev_addr_valid <= addr_valid;
            prev_addr_ready <= addr_ready;
            prev_data_valid <= data_valid;
            prev_data_ready <= data_ready;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (BURST_EN && data_hs && have_head) begin
                beat_cnt <= pop ? 8'd0 : beat_cnt + 8'd1;
            end

            // Detected violations pass through one register before reaching the outputs.
            err_pend  <= err_vec;
            err_valid <= |err_pend;
            err_code  <= pend_code;
            err_mask  <= err_mask | err_pend;
            if ((|err_pend) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    assign outstanding = count;

endmodule
